// File: rtl/mac_result_drain_if.sv
// Result handshake between the MAC result drain and the output-buffer writer.
`timescale 1ns/1ps
interface mac_result_drain_if #(
  parameter int unsigned RESW = 16
) ();
  logic [RESW-1:0] res_data;
  logic            res_valid;
  logic            res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/mac_result_drain.sv
// MAC result drain: waits out MAC latency, samples the accumulator, rounds,
// shifts, saturates, optionally applies ReLU, and queues results in a small FIFO.
`timescale 1ns/1ps
module mac_result_drain #(
  parameter int unsigned OUTW        = 64,
  parameter int unsigned RESW        = 16,
  parameter int unsigned SHW         = 6,
  parameter int unsigned MAC_LATENCY = 6,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned AF_LEVEL    = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [OUTW-1:0] mac_out,
  input  logic                   acc_done,
  input  logic [SHW-1:0]         cfg_shift,
  input  logic                   cfg_relu_en,
  input  logic                   clr_overflow,
  mac_result_drain_if.master     res,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [15:0]            res_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Saturation bounds expressed at the OUTW+1 intermediate width.
  localparam logic signed [OUTW:0] SatMax = {{(OUTW-RESW+2){1'b0}}, {(RESW-1){1'b1}}};
  localparam logic signed [OUTW:0] SatMin = {{(OUTW-RESW+2){1'b1}}, {(RESW-1){1'b0}}};

  logic [MAC_LATENCY-1:0] done_q;
  logic                   cap_en;

  logic                   a_valid_q;
  logic signed [OUTW-1:0] a_mac_q;
  logic [SHW-1:0]         a_shift_q;
  logic                   a_relu_q;

  logic signed [OUTW:0]   a_ext;
  logic signed [OUTW:0]   round_d;
  logic signed [OUTW:0]   sum_d;
  logic signed [OUTW:0]   tmp_d;

  logic                   b_valid_q;
  logic signed [OUTW:0]   b_tmp_q;
  logic                   b_relu_q;

  logic signed [RESW-1:0] c_res;

  logic [RESW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [RESW-1:0]        last_q;
  logic [15:0]            res_count_q;
  logic                   overflow_q;
  logic                   push, pop, push_ok, drop;

  assign cap_en = done_q[MAC_LATENCY-1];

  // Delay line of acc_done covering the MAC pipeline latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= '0;
    else       done_q <= (done_q << 1) | MAC_LATENCY'(acc_done);
  end

  // Stage A: sample accumulator and per-result config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_mac_q   <= '0;
      a_shift_q <= '0;
      a_relu_q  <= 1'b0;
    end else begin
      a_valid_q <= cap_en;
      if (cap_en) begin
        a_mac_q   <= mac_out;
        a_shift_q <= cfg_shift;
        a_relu_q  <= cfg_relu_en;
      end
    end
  end

  // Round-half-up arithmetic right shift at OUTW+1 bits so the add cannot wrap.
  always_comb begin
    a_ext   = {a_mac_q[OUTW-1], a_mac_q};
    round_d = '0;
    if (a_shift_q != '0) round_d = (OUTW+1)'(1) << (a_shift_q - 1'b1);
    sum_d   = a_ext + round_d;
    tmp_d   = sum_d >>> a_shift_q;
  end

  // Stage B: hold shifted value for saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_tmp_q   <= '0;
      b_relu_q  <= 1'b0;
    end else begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_tmp_q  <= tmp_d;
        b_relu_q <= a_relu_q;
      end
    end
  end

  // Stage C: saturate, then ReLU; result goes straight into the FIFO.
  always_comb begin
    if (b_tmp_q > SatMax)      c_res = SatMax[RESW-1:0];
    else if (b_tmp_q < SatMin) c_res = SatMin[RESW-1:0];
    else                       c_res = b_tmp_q[RESW-1:0];
    if (b_relu_q && c_res[RESW-1]) c_res = '0;
  end

  // Push/pop decisions; a full FIFO still accepts when a pop frees a slot this cycle.
  always_comb begin
    push    = b_valid_q;
    pop     = (count_q != '0) && res.res_ready;
    push_ok = push && ((count_q < CW'(FIFO_DEPTH)) || pop);
    drop    = push && !push_ok;
  end

  // FIFO storage, pointers, occupancy, pop counter and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
      res_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= c_res;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_q      <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        res_count_q <= res_count_q + 16'd1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // Outputs; when empty the last popped head is held so res_data is never stale X.
  always_comb begin
    res.res_valid = (count_q != '0);
    res.res_data  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    almost_full   = (count_q >= CW'(AF_LEVEL));
    overflow      = overflow_q;
    res_count     = res_count_q;
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Randomised and directed bench for mac_result_drain with a queue-based reference model.
`timescale 1ns/1ps
module tb_mac_result_drain;
  localparam int L  = 6;
  localparam int D  = 8;
  localparam int AF = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [63:0] mac_out = '0;
  logic               acc_done = 1'b0;
  logic [5:0]         cfg_shift = '0;
  logic               cfg_relu_en = 1'b0;
  logic               clr_overflow = 1'b0;
  logic               almost_full, overflow;
  logic [15:0]        res_count;

  mac_result_drain_if #(.RESW(16)) res_if ();

  mac_result_drain dut (
    .clk          (clk),
    .reset        (reset),
    .mac_out      (mac_out),
    .acc_done     (acc_done),
    .cfg_shift    (cfg_shift),
    .cfg_relu_en  (cfg_relu_en),
    .clr_overflow (clr_overflow),
    .res          (res_if),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .res_count    (res_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Quantisation reference: floor division after adding half an LSB, then clamp and ReLU.
  function automatic logic [15:0] ref_q(input logic signed [63:0] m, input int sh,
                                        input bit relu);
    logic signed [127:0] v, d, q;
    v = m;
    d = 128'sd1 <<< sh;
    if (sh > 0) v = v + d / 2;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (q > 32767)       q = 32767;
    else if (q < -32768) q = -32768;
    if (relu && q < 0)   q = 0;
    return q[15:0];
  endfunction

  // Reference model state.
  typedef struct { int c; logic [15:0] v; } wr_t;
  int          cyc = 0;
  int          cap_q[$];
  wr_t         wr_q[$];
  logic [15:0] fifo_m[$];
  bit          ov_m = 0;
  logic [15:0] cnt_m = '0;
  logic [15:0] last_m = '0;
  bit          m_pop, m_drop;
  wr_t         m_w;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q.delete(); wr_q.delete(); fifo_m.delete();
      ov_m = 0; cnt_m = '0; last_m = '0;
    end else begin
      m_pop  = (fifo_m.size() > 0) && res_if.res_ready;
      m_drop = 0;
      if (m_pop) begin
        last_m = fifo_m.pop_front();
        cnt_m  = cnt_m + 16'd1;
      end
      if (wr_q.size() > 0 && wr_q[0].c == cyc) begin
        m_w = wr_q.pop_front();
        if (fifo_m.size() < D) fifo_m.push_back(m_w.v);
        else                   m_drop = 1;
      end
      if (m_drop)            ov_m = 1;
      else if (clr_overflow) ov_m = 0;
      if (cap_q.size() > 0 && cap_q[0] == cyc) begin
        void'(cap_q.pop_front());
        m_w.c = cyc + 2;
        m_w.v = ref_q(mac_out, int'(cfg_shift), cfg_relu_en);
        wr_q.push_back(m_w);
      end
      if (acc_done) cap_q.push_back(cyc + L);
      cyc++;
    end
  end

  // Monitor: compare DUT outputs against the model head every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("res_valid", res_if.res_valid, fifo_m.size() != 0);
      if (fifo_m.size() != 0) chk("res_data_head", res_if.res_data, fifo_m[0]);
      else                    chk("res_data_hold", res_if.res_data, last_m);
      chk("almost_full", almost_full, fifo_m.size() >= AF);
      chk("overflow", overflow, ov_m);
      chk("res_count", res_count, cnt_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_result(input logic signed [63:0] m, input int sh, input bit relu,
                            input logic [15:0] exp, input string nm);
    int lat;
    bit seen;
    lat = 0;
    seen = 0;
    mac_out = m; cfg_shift = sh[5:0]; cfg_relu_en = relu; res_if.res_ready = 1'b1;
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!seen && res_if.res_valid) begin
        seen = 1;
        lat  = k;
        chk(nm, res_if.res_data, exp);
      end
    end
    chk({nm, "_latency"}, lat, L + 3);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    res_if.res_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", res_if.res_valid, 0);
    chk("rst_data", res_if.res_data, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", res_count, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Latency, rounding, ReLU, saturation.
    one_result(64'sd1000, 4, 0, 16'd63, "round_pos");
    one_result(-64'sd1000, 4, 0, 16'(-62), "round_neg");
    one_result(-64'sd1000, 4, 1, 16'd0, "relu_neg");
    one_result(64'sd24, 4, 1, 16'd2, "relu_pos");
    one_result(64'sd1 <<< 40, 0, 0, 16'h7fff, "sat_pos");
    one_result(-(64'sd1 <<< 40), 0, 0, 16'h8000, "sat_neg");
    one_result(-64'sd32768, 0, 0, 16'h8000, "sat_edge");

    // Back-pressure: 10 back-to-back results into an 8-deep FIFO.
    res_if.res_ready = 1'b0;
    cfg_shift = '0; cfg_relu_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      acc_done = (k < 10);
      mac_out  = (k >= 6) ? 64'(k - 5) : 64'sd0;
      tick();
    end
    acc_done = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bp_overflow", overflow, 1);
    chk("bp_almost_full", almost_full, 1);
    tick();
    res_if.res_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("bp_order_valid", res_if.res_valid, 1);
      chk("bp_order_data", res_if.res_data, i);
      tick();
    end
    @(negedge clk);
    chk("bp_empty", res_if.res_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    @(negedge clk);
    chk("bp_ovf_clear", overflow, 0);
    tick();

    // Full FIFO with a simultaneous pop: the ninth push must be accepted.
    for (int k = 0; k < 21; k++) begin
      acc_done         = (k < 9);
      res_if.res_ready = (k == 16);
      mac_out          = 64'(200 + k);
      tick();
    end
    @(negedge clk);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_af", almost_full, 1);
    chk("fullpop_head", res_if.res_data, 207);
    tick();
    res_if.res_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("fullpop_drained", res_if.res_valid, 0);
    tick();

    // Reset with results both in the delay line and in the FIFO.
    res_if.res_ready = 1'b0;
    mac_out = 64'sd77;
    for (int k = 0; k < 11; k++) begin
      acc_done = (k == 0 || k == 1 || k == 7 || k == 8 || k == 9);
      tick();
    end
    acc_done = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", res_if.res_valid, 0);
    chk("midrst_data", res_if.res_data, 0);
    chk("midrst_count", res_count, 0);
    chk("midrst_af", almost_full, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", res_if.res_valid, 0);
    end
    tick();
    one_result(64'sd500, 2, 0, 16'd125, "post_reset");

    // Randomised traffic with random back-pressure and config.
    for (int k = 0; k < 400; k++) begin
      acc_done = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: mac_out = 64'(int'($urandom_range(0, 4000)) - 2000);
        1: mac_out = {$urandom, $urandom};
        2: mac_out = 64'($signed($urandom));
        default: mac_out = 64'(int'($urandom_range(0, 200000)) - 100000);
      endcase
      cfg_shift        = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(0, 20));
      cfg_relu_en      = ($urandom_range(0, 1) == 1);
      res_if.res_ready = ($urandom_range(0, 9) < 7);
      clr_overflow     = ($urandom_range(0, 19) == 0);
      tick();
    end
    acc_done = 1'b0;
    clr_overflow = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (25) tick();
    @(negedge clk);
    chk("final_empty", res_if.res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Sits directly downstream of the pipelined MAC in the 2D convolution datapath.
- When the sequencer flags the last tap of an output pixel, the block waits out the MAC latency and samples the MAC accumulator.
- It then applies round-half-up right shift, signed saturation and optional ReLU, and queues the result in a small FIFO.
- The FIFO drains through a valid/ready handshake to the output-buffer writer.

Parameters:
- OUTW, 64, width of MAC accumulator input mac_out.
- RESW, 16, width of quantised result.
- SHW, 6, width of cfg_shift.
- MAC_LATENCY, 6, cycles from acc_done (issued with the last input_valid to the MAC) until mac_out holds the final sum.
- FIFO_DEPTH, 8, result FIFO entries (power of two, >=2).
- AF_LEVEL, 6, FIFO occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous active-high reset.
- mac_out  in  OUTW  signed MAC accumulator value.
- acc_done  in  1  one-cycle pulse, coincident with last input_valid of a pixel.
- cfg_shift  in  SHW  right-shift amount, 0..OUTW-1.
- cfg_relu_en  in  1  1 = clamp negative results to 0.
- clr_overflow  in  1  synchronous clear of overflow flag.
- res_data  out  RESW  signed quantised result, head of FIFO.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer accepts res_data this cycle.
- almost_full  out  1  FIFO count >= AF_LEVEL; sequencer stalls new pixels.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- res_count  out  16  number of results popped, wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release):
  - Done delay line, both stage valids and the FIFO are emptied.
  - res_valid=0, res_data=0, almost_full=0, overflow=0, res_count=0.
  - In-flight results are discarded.
- Delay line: a MAC_LATENCY-deep shift register of acc_done. With acc_done high in cycle t, the capture enable is high in cycle t+MAC_LATENCY.
- Stage A, end of cycle t+MAC_LATENCY:
  - Register mac_out, cfg_shift and cfg_relu_en.
  - Config is therefore sampled per result; changing it mid-stream affects only later captures.
- Stage B, next edge:
  - tmp = (mac_out + (shift>0 ? 2^(shift-1) : 0)) >>> shift.
  - Add performed at OUTW+1 bits; arithmetic shift; no wrap.
- Stage C, next edge, produces the FIFO write:
  - Saturate tmp to [-2^(RESW-1), 2^(RESW-1)-1].
  - Then, if relu_en and the value is negative, force 0.
  - Write to FIFO at end of cycle t+MAC_LATENCY+2.
- res_valid rises in cycle t+MAC_LATENCY+3 when the FIFO was empty, giving a total latency of MAC_LATENCY+3.
- Stages are fully pipelined: acc_done may pulse every cycle, giving one result per cycle.
- FIFO:
  - Registered read pointer; res_data always shows the head entry.
  - Pop when res_valid && res_ready; res_count increments on each pop.
  - Push accepted if count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle.
  - Otherwise the result is dropped, FIFO contents are unchanged, and overflow sets.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Pop when empty: ignored; res_ready has no effect while res_valid=0.
- Pointers wrap modulo FIFO_DEPTH.
- almost_full is combinational on the registered count, with no lookahead for in-flight results. The sequencer must reserve MAC_LATENCY+2 slots of headroom through AF_LEVEL.
- Overflow flag:
  - clr_overflow clears it.
  - If clr_overflow coincides with a new drop, the flag stays 1 (set wins).
- res_data is undefined-free: it holds the last head value (0 after reset) when empty.
- acc_done pulses closer together than the MAC's own requirements are the sequencer's responsibility; this block treats every pulse independently.

Test Plan:
- Latency and round, MAC_LATENCY=6, shift=4, relu=0: pulse acc_done at cycle 10, mac_out=1000 in cycle 16 -> res_valid rises in cycle 19, res_data=63; negative case mac_out=-1000 -> -62.
- ReLU: same setup with relu_en=1, mac_out=-1000 -> res_data=0; mac_out=24 with shift=4 -> 2 (24+8=32, >>4).
- Saturation, RESW=16, shift=0: mac_out=2^40 -> 32767; mac_out=-2^40 -> -32768; mac_out=-32768 -> -32768 unchanged.
- Throughput and back-pressure: 10 consecutive acc_done pulses (values 1..10, shift 0), res_ready=0 until all queued:
  - Exactly 8 stored; overflow=1; almost_full=1 from count 6.
  - Raise res_ready -> outputs 1..8 in order on consecutive cycles; res_count=8; overflow remains 1 until clr_overflow.
- Full with simultaneous pop: fill FIFO, hold res_ready=1 while a new result arrives -> push accepted, no overflow, count stays 8.
- Reset mid-operation: assert reset asynchronously while 3 results are in the delay line and 2 in the FIFO -> outputs 0 immediately; after release no stale res_valid appears; the next acc_done produces a correct result at MAC_LATENCY+3.
